// File: rtl/core_pkg.sv
// core_pkg: shared state, class, opcode and mux-select encodings for the core control path
package core_pkg;
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;
    typedef enum logic [2:0] {CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_JUMP} op_class_t;
    localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2;
    localparam logic [1:0] PC_PLUS4 = 2'd0, PC_REL = 2'd1, PC_JALR = 2'd2;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
endpackage

// File: rtl/core_ctrl_fsm_if.sv
// core_ctrl_fsm_if: control-unit handshake bundle; master is the FSM, slave is the datapath side
interface core_ctrl_fsm_if #(parameter int CNT_W = 32);
    logic [6:0]       I_op;
    logic             I_br_taken;
    logic             I_imem_ready;
    logic             I_dmem_ready;
    logic             I_stall;
    logic             O_imem_req;
    logic             O_ir_we;
    logic             O_dec_en;
    logic             O_alu_en;
    logic             O_dmem_re;
    logic             O_dmem_we;
    logic             O_rf_we;
    logic [1:0]       O_wb_sel;
    logic             O_pc_we;
    logic [1:0]       O_pc_sel;
    logic             O_trap;
    logic [2:0]       O_state;
    logic [CNT_W-1:0] O_retired;
    modport master (
        input  I_op, I_br_taken, I_imem_ready, I_dmem_ready, I_stall,
        output O_imem_req, O_ir_we, O_dec_en, O_alu_en, O_dmem_re, O_dmem_we,
               O_rf_we, O_wb_sel, O_pc_we, O_pc_sel, O_trap, O_state, O_retired
    );
    modport slave (
        output I_op, I_br_taken, I_imem_ready, I_dmem_ready, I_stall,
        input  O_imem_req, O_ir_we, O_dec_en, O_alu_en, O_dmem_re, O_dmem_we,
               O_rf_we, O_wb_sel, O_pc_we, O_pc_sel, O_trap, O_state, O_retired
    );
endinterface

// File: rtl/core_ctrl_fsm_op_classify.sv
// op_classify: combinational opcode to {class, wb_sel, pc_sel, legal} lookup
module op_classify
    import core_pkg::*;
(
    input  logic [6:0] op,
    output op_class_t  cls,
    output logic [1:0] wb_sel,
    output logic [1:0] pc_sel,
    output logic       legal
);
    always_comb begin
        cls    = CL_ALU;
        wb_sel = WB_ALU;
        pc_sel = PC_PLUS4;
        legal  = 1'b1;
        case (op)
            OP_IMM, OP_R, OP_LUI, OP_AUIPC: ;
            OP_LOAD: begin
                cls    = CL_LOAD;
                wb_sel = WB_MEM;
            end
            OP_STORE:  cls = CL_STORE;
            OP_BRANCH: cls = CL_BRANCH;
            OP_JAL: begin
                cls    = CL_JUMP;
                wb_sel = WB_PC4;
                pc_sel = PC_REL;
            end
            OP_JALR: begin
                cls    = CL_JUMP;
                wb_sel = WB_PC4;
                pc_sel = PC_JALR;
            end
            default: legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm: multi-cycle fetch/decode/exec/mem/wb sequencer with sticky trap and retire counter
module core_ctrl_fsm
    import core_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
)
(
    input logic             clk,
    input logic             rst,
    core_ctrl_fsm_if.master bus
);
    localparam int TW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT + 1) : 1;
    state_t         state, next;
    op_class_t      cls, cls_q;
    logic [1:0]     wb_sel, pc_sel, wb_sel_q, pc_sel_q;
    logic           legal, run, mem_done, tmo, retire;
    logic [TW-1:0]  tmo_cnt;
    logic [CNT_W-1:0] retired;
    op_classify u_cls (.op(bus.I_op), .cls(cls), .wb_sel(wb_sel), .pc_sel(pc_sel), .legal(legal));
    assign run      = !rst;
    assign mem_done = state == S_MEM && bus.I_dmem_ready;
    // Trap on the cycle the counter would reach MEM_TIMEOUT; a ready in that cycle still wins.
    assign tmo      = MEM_TIMEOUT != 0 && tmo_cnt == TW'(MEM_TIMEOUT - 1);
    assign retire   = (state == S_EXEC && cls == CL_BRANCH) || (mem_done && cls_q == CL_STORE) || state == S_WB;
    always_ff @(posedge clk)
        state <= rst ? S_FETCH : next;
    always_comb begin
        next = state;
        case (state)
            S_FETCH:  next = bus.I_imem_ready && !bus.I_stall ? S_DECODE : S_FETCH;
            S_DECODE: next = S_EXEC;
            S_EXEC:   next = !legal ? S_TRAP
                           : cls == CL_BRANCH ? S_FETCH
                           : (cls == CL_LOAD || cls == CL_STORE) ? S_MEM : S_WB;
            S_MEM:    next = bus.I_dmem_ready ? (cls_q == CL_LOAD ? S_WB : S_FETCH)
                           : tmo ? S_TRAP : S_MEM;
            S_WB:     next = S_FETCH;
            default:  next = S_TRAP;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cls_q    <= CL_ALU;
            wb_sel_q <= WB_ALU;
            pc_sel_q <= PC_PLUS4;
            tmo_cnt  <= '0;
            retired  <= '0;
        end else begin
            if (state == S_EXEC) begin
                cls_q    <= cls;
                wb_sel_q <= wb_sel;
                pc_sel_q <= pc_sel;
            end
            tmo_cnt <= state == S_MEM && next == S_MEM ? tmo_cnt + 1'b1 : '0;
            if (retire) retired <= retired + 1'b1;
        end
    end
    always_comb begin
        bus.O_state    = state;
        bus.O_retired  = retired;
        bus.O_imem_req = run && state == S_FETCH && !bus.I_stall;
        bus.O_ir_we    = run && state == S_FETCH && bus.I_imem_ready && !bus.I_stall;
        bus.O_dec_en   = run && state == S_DECODE;
        bus.O_alu_en   = run && state == S_EXEC;
        bus.O_dmem_re  = run && state == S_MEM && cls_q == CL_LOAD;
        bus.O_dmem_we  = run && state == S_MEM && cls_q == CL_STORE;
        bus.O_rf_we    = run && state == S_WB;
        bus.O_wb_sel   = run && state == S_WB ? wb_sel_q : WB_ALU;
        bus.O_pc_we    = run && retire;
        bus.O_pc_sel   = !run ? PC_PLUS4
                       : state == S_EXEC && cls == CL_BRANCH ? (bus.I_br_taken ? PC_REL : PC_PLUS4)
                       : state == S_WB ? pc_sel_q : PC_PLUS4;
        bus.O_trap     = run && state == S_TRAP;
    end
endmodule

// File: tb/tb_core_ctrl_fsm.sv
// tb_core_ctrl_fsm: directed per-cycle expectations queued by stimulus, checked by a negedge monitor
module tb_core_ctrl_fsm;
    import core_pkg::*;
    localparam logic [12:0] IMR = 13'h1000, IRW = 13'h0800, DEC = 13'h0400, ALU = 13'h0200;
    localparam logic [12:0] DRE = 13'h0100, DWE = 13'h0080, RFW = 13'h0040, WB2 = 13'h0020;
    localparam logic [12:0] WB1 = 13'h0010, PCW = 13'h0008, PS2 = 13'h0004, PS1 = 13'h0002, TRP = 13'h0001;
    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [12:0] stb;
        logic [31:0] ret;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    core_ctrl_fsm_if #(.CNT_W(32)) bus ();
    core_ctrl_fsm #(.CNT_W(32), .MEM_TIMEOUT(15)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    exp_t        q[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ret_m = '0;
    logic [12:0] act;
    assign act = {bus.O_imem_req, bus.O_ir_we, bus.O_dec_en, bus.O_alu_en, bus.O_dmem_re, bus.O_dmem_we,
                  bus.O_rf_we, bus.O_wb_sel, bus.O_pc_we, bus.O_pc_sel, bus.O_trap};
    always @(negedge clk) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if (bus.O_state !== e.st || act !== e.stb || bus.O_retired !== e.ret) begin
                errors++;
                $display("FAIL %s: got state=%0d strobes=%h retired=%0d, expected state=%0d strobes=%h retired=%0d",
                         e.tag, bus.O_state, act, bus.O_retired, e.st, e.stb, e.ret);
            end
        end
    end
    task automatic step(input string tag, input logic [2:0] st, input logic [12:0] stb);
        q.push_back('{tag, st, stb, ret_m});
        @(posedge clk);
        #1;
    endtask
    task automatic fd(input string tag, input logic [6:0] op, input logic br);
        bus.I_op = op;
        bus.I_br_taken = br;
        bus.I_imem_ready = 1'b1;
        bus.I_stall = 1'b0;
        bus.I_dmem_ready = 1'b1;
        step({tag, "_F"}, S_FETCH, IMR | IRW);
        step({tag, "_D"}, S_DECODE, DEC);
    endtask
    task automatic wb_like(input string tag, input logic [6:0] op, input logic [12:0] sel);
        fd(tag, op, 1'b0);
        step({tag, "_E"}, S_EXEC, ALU);
        step({tag, "_W"}, S_WB, RFW | PCW | sel);
        ret_m++;
    endtask
    task automatic br_op(input string tag, input logic br);
        fd(tag, OP_BRANCH, br);
        step({tag, "_E"}, S_EXEC, ALU | PCW | (br ? PS1 : 13'h0));
        ret_m++;
    endtask
    task automatic mem_op(input string tag, input logic [6:0] op, input int waits, input logic store);
        fd(tag, op, 1'b0);
        step({tag, "_E"}, S_EXEC, ALU);
        bus.I_dmem_ready = 1'b0;
        repeat (waits) step({tag, "_Mw"}, S_MEM, store ? DWE : DRE);
        bus.I_dmem_ready = 1'b1;
        if (store) begin
            step({tag, "_Md"}, S_MEM, DWE | PCW);
            ret_m++;
        end else begin
            step({tag, "_Md"}, S_MEM, DRE);
            step({tag, "_W"}, S_WB, RFW | PCW | WB1);
            ret_m++;
        end
    endtask
    initial begin
        bus.I_op = '0;
        bus.I_br_taken = 1'b0;
        bus.I_imem_ready = 1'b1;
        bus.I_dmem_ready = 1'b1;
        bus.I_stall = 1'b0;
        @(posedge clk);
        #1;
        step("rst_idle", S_FETCH, 13'h0);
        rst = 1'b0;
        wb_like("addi", OP_IMM, 13'h0);
        br_op("beq_t", 1'b1);
        br_op("beq_nt", 1'b0);
        mem_op("lw_w3", OP_LOAD, 3, 1'b0);
        mem_op("sw_w1", OP_STORE, 1, 1'b1);
        wb_like("jal", OP_JAL, WB2 | PS1);
        wb_like("jalr", OP_JALR, WB2 | PS2);
        wb_like("lui", OP_LUI, 13'h0);
        wb_like("auipc", OP_AUIPC, 13'h0);
        wb_like("add", OP_R, 13'h0);
        mem_op("lw_w14", OP_LOAD, 14, 1'b0);
        bus.I_stall = 1'b1;
        step("stall1", S_FETCH, 13'h0);
        step("stall2", S_FETCH, 13'h0);
        fd("ill", 7'b0000000, 1'b0);
        step("ill_E", S_EXEC, ALU);
        repeat (3) step("ill_T", S_TRAP, TRP);
        rst = 1'b1;
        step("rst_trap", S_TRAP, 13'h0);
        rst = 1'b0;
        ret_m = '0;
        fd("lwto", OP_LOAD, 1'b0);
        step("lwto_E", S_EXEC, ALU);
        bus.I_dmem_ready = 1'b0;
        repeat (15) step("lwto_M", S_MEM, DRE);
        repeat (2) step("lwto_T", S_TRAP, TRP);
        rst = 1'b1;
        step("rst_trap2", S_TRAP, 13'h0);
        rst = 1'b0;
        wb_like("addi2", OP_IMM, 13'h0);
        fd("lwrst", OP_LOAD, 1'b0);
        step("lwrst_E", S_EXEC, ALU);
        bus.I_dmem_ready = 1'b0;
        repeat (2) step("lwrst_M", S_MEM, DRE);
        rst = 1'b1;
        step("rst_mem", S_MEM, 13'h0);
        ret_m = '0;
        bus.I_stall = 1'b1;
        bus.I_imem_ready = 1'b1;
        step("rst_stall", S_FETCH, 13'h0);
        rst = 1'b0;
        step("stall_post", S_FETCH, 13'h0);
        bus.I_stall = 1'b0;
        step("fetch_go", S_FETCH, IMR | IRW);
        step("dec_go", S_DECODE, DEC);
        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
